// File: rtl/illusion_fb_pkg.sv
// Shared types and constant helpers for the frame buffer controller.
// Base addresses are chosen by a constant mux on the buffer index, never multiplied at runtime.
package illusion_fb_pkg;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic {StRender, StWaitFlip} flip_state_e;

  localparam int unsigned CoordBits = 10;

  function automatic int unsigned frame_pixels(int unsigned width, int unsigned height);
    return width * height;
  endfunction

  function automatic int unsigned buf_base(buf_idx_t idx, int unsigned pixels);
    case (idx)
      2'd1:    return pixels;
      2'd2:    return 2 * pixels;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned clamp_coord(int unsigned v, int unsigned limit);
    return (v > limit) ? limit : v;
  endfunction

endpackage

// File: rtl/fb_address_gen.sv
// Registered address generator: clamp x/y, scale y by the row width, add the buffer base.
// The write path reuses it with the frame treated as one long row.
module fb_address_gen
  import illusion_fb_pkg::*;
#(
  parameter int unsigned Width  = 320,
  parameter int unsigned Height = 240,
  parameter int unsigned CoordW = 10,
  parameter int unsigned MemAw  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MemAw-1:0]  base,
  input  logic [CoordW-1:0] x,
  input  logic [CoordW-1:0] y,
  output logic [MemAw-1:0]  addr
);

  logic [MemAw-1:0] x_c, y_c, addr_d, addr_q;

  always_comb begin
    x_c    = MemAw'(clamp_coord(32'(x), Width - 1));
    y_c    = MemAw'(clamp_coord(32'(y), Height - 1));
    addr_d = base + y_c * MemAw'(Width) + x_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (en) begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/frame_buffer_controller.sv
// Double/triple framebuffer manager: steers renderer writes and scan-out reads,
// flipping buffers only on frame start; triple mode acts as a mailbox that drops stale frames.
module frame_buffer_controller
  import illusion_fb_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS = 2,
  parameter int unsigned FB_WIDTH    = 320,
  parameter int unsigned FB_HEIGHT   = 240,
  parameter int unsigned PIXEL_BITS  = 3,
  parameter int unsigned MEM_AW      = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  frame_done,
  input  logic                  write_valid,
  input  logic [MEM_AW-1:0]     write_address,
  input  logic [PIXEL_BITS-1:0] write_data,
  output logic                  write_ready,
  input  logic [CoordBits-1:0]  read_x,
  input  logic [CoordBits-1:0]  read_y,
  output logic [MEM_AW-1:0]     mem_read_address,
  output logic [MEM_AW-1:0]     mem_write_address,
  output logic [PIXEL_BITS-1:0] mem_write_data,
  output logic                  mem_write_enable,
  output logic                  frame_flipped,
  output logic [15:0]           dropped_frames
);

  localparam int unsigned FramePixels = frame_pixels(FB_WIDTH, FB_HEIGHT);
  localparam bit          Triple      = (NUM_BUFFERS == 3);

  flip_state_e           state_q, state_d;
  buf_idx_t              display_q, display_d, render_q, render_d, spare_q, spare_d;
  logic                  pending_q, pending_d;
  logic [15:0]           dropped_q, dropped_d;
  logic                  flipped_q, flipped_d;
  logic                  drop_inc;
  logic                  we_q, wr_accept;
  logic [PIXEL_BITS-1:0] wdata_q;
  logic [MEM_AW-1:0]     display_base, render_base;

  assign display_base = MEM_AW'(buf_base(display_q, FramePixels));
  assign render_base  = MEM_AW'(buf_base(render_q, FramePixels));

  assign write_ready = Triple ? 1'b1 : (state_q == StRender);
  assign wr_accept   = write_valid && write_ready && (write_address < MEM_AW'(FramePixels));

  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    render_d  = render_q;
    spare_d   = spare_q;
    pending_d = pending_q;
    dropped_d = dropped_q;
    flipped_d = 1'b0;
    drop_inc  = 1'b0;
    if (Triple) begin
      if (frame_done && frame_start) begin
        // Freshly completed frame goes straight to display; any mailbox frame is lost.
        display_d = render_q;
        render_d  = display_q;
        pending_d = 1'b0;
        flipped_d = 1'b1;
        drop_inc  = pending_q;
      end else if (frame_done) begin
        render_d  = spare_q;
        spare_d   = render_q;
        pending_d = 1'b1;
        drop_inc  = pending_q;
      end else if (frame_start && pending_q) begin
        display_d = spare_q;
        spare_d   = display_q;
        pending_d = 1'b0;
        flipped_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StRender: begin
          if (frame_done && frame_start) begin
            display_d = render_q;
            render_d  = display_q;
            flipped_d = 1'b1;
          end else if (frame_done) begin
            state_d = StWaitFlip;
          end
        end
        StWaitFlip: begin
          if (frame_start) begin
            display_d = render_q;
            render_d  = display_q;
            flipped_d = 1'b1;
            state_d   = StRender;
          end
        end
        default: state_d = StRender;
      endcase
    end
    if (drop_inc && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRender;
      display_q <= 2'd0;
      render_q  <= 2'd1;
      spare_q   <= 2'd2;
      pending_q <= 1'b0;
      dropped_q <= '0;
      flipped_q <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      render_q  <= render_d;
      spare_q   <= spare_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      flipped_q <= flipped_d;
      we_q      <= wr_accept;
      if (wr_accept) begin
        wdata_q <= write_data;
      end
    end
  end

  fb_address_gen #(
    .Width (FB_WIDTH),
    .Height(FB_HEIGHT),
    .CoordW(CoordBits),
    .MemAw (MEM_AW)
  ) u_read_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .base (display_base),
    .x    (read_x),
    .y    (read_y),
    .addr (mem_read_address)
  );

  // Linear pixel index: one row of FramePixels, y tied off.
  fb_address_gen #(
    .Width (FramePixels),
    .Height(1),
    .CoordW(MEM_AW),
    .MemAw (MEM_AW)
  ) u_write_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (wr_accept),
    .base (render_base),
    .x    (write_address),
    .y    ('0),
    .addr (mem_write_address)
  );

  assign mem_write_data   = wdata_q;
  assign mem_write_enable = we_q;
  assign frame_flipped    = flipped_q;
  assign dropped_frames   = dropped_q;

endmodule
